ex_timer_tick: RTL

- Free-running time base for the core.
- Produces the 12-bit `timers` vector consumed by the CPUID block:
  - `timers[0]` is the RNG noise source.
  - `timers[11:8]` is reported as the clock-class nibble.
- Also holds the 64-bit microsecond counter that is read back as the timer register.
- Holds a programmable interval tick for the interrupt path.

---
 rtl/ex_timer_tick_pkg.sv | 18 +
 rtl/ex_tick_div.sv | 27 ++
 rtl/ex_timer_tick.sv | 90 +++++++++
 3 files changed

// File: rtl/ex_timer_tick_pkg.sv
// Shared constants for the core time base: bit positions in the timers vector
// and the configuration-select codes.
package ex_timer_tick_pkg;

  localparam int TMR_US      = 0;
  localparam int TMR_MS      = 1;
  localparam int TMR_S       = 2;
  localparam int TMR_IV      = 3;
  localparam int TMR_FREQ_LO = 8;

  typedef enum logic [1:0] {
    CFGSEL_NONE   = 2'b00,
    CFGSEL_PERIOD = 2'b01,
    CFGSEL_USCNT  = 2'b10,
    CFGSEL_RSVD   = 2'b11
  } cfgSelE;

endpackage

// File: rtl/ex_tick_div.sv
// Modulo-N event divider: counts enabled cycles 0..N-1 and flags the wrapping
// cycle combinationally so dividers can be chained without added latency.
module ex_tick_div #(
  parameter int N = 1000,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  logic [W-1:0] count;

  assign wrap = enable && (count == W'(N - 1));

  // NOTE: state is updated with non-blocking assignments so every divider in
  // the chain samples its neighbours' pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_timer_tick.sv
// Free-running core time base: microsecond prescaler, ms/s dividers, a
// programmable interval tick and the 64-bit microsecond counter.
module ex_timer_tick
  import ex_timer_tick_pkg::*;
#(
  parameter int          CLK_MHZ   = 50,
  parameter logic [3:0]  FREQ_CODE = 4'h5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic [1:0]  cfgSel,
  input  logic [63:0] cfgData,
  output logic [11:0] timers,
  output logic [63:0] usCount,
  output logic [23:0] period
);

  logic        run;
  logic        clear;
  logic        usEv;
  logic        msEv;
  logic        sEv;
  logic        ivEv;
  logic [23:0] ivCnt;
  logic [3:0]  ticks;

  assign run   = !hold;
  assign clear = !reset;

  // Gating the prescaler enable with hold also silences every downstream event.
  ex_tick_div #(.N(CLK_MHZ), .W(8)) uPsc (
    .clock  (clock),
    .clear  (clear),
    .enable (run),
    .wrap   (usEv)
  );

  ex_tick_div #(.N(1000), .W(10)) uMsDiv (
    .clock  (clock),
    .clear  (clear),
    .enable (usEv),
    .wrap   (msEv)
  );

  ex_tick_div #(.N(1000), .W(10)) uSDiv (
    .clock  (clock),
    .clear  (clear),
    .enable (msEv),
    .wrap   (sEv)
  );

  assign ivEv = usEv && (period != '0) && (ivCnt == period - 24'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ticks   <= '0;
      ivCnt   <= '0;
      period  <= '0;
      usCount <= '0;
    end else begin
      ticks[TMR_US] <= usEv;
      ticks[TMR_MS] <= msEv;
      ticks[TMR_S]  <= sEv;

      // A period write restarts the interval and suppresses a coincident tick.
      if (cfgSel == CFGSEL_PERIOD) begin
        period        <= cfgData[23:0];
        ivCnt         <= '0;
        ticks[TMR_IV] <= 1'b0;
      end else begin
        ticks[TMR_IV] <= ivEv;
        if (usEv && (period != '0)) begin
          ivCnt <= ivEv ? '0 : ivCnt + 24'd1;
        end
      end

      if (cfgSel == CFGSEL_USCNT) begin
        usCount <= cfgData;
      end else if (usEv) begin
        usCount <= usCount + 64'd1;
      end
    end
  end

  assign timers[TMR_FREQ_LO +: 4] = FREQ_CODE;
  assign timers[7:4]              = 4'h0;
  assign timers[3:0]              = ticks;

endmodule
